// File: rtl/reg_shift_pload_pkg.sv
// Shared types and constants for the reg_shift_pload PISO transmitter.
// Optional LSB-first ordering is selected by REG_SHIFT_PLOAD_LSB_FIRST_EN in the top.
package reg_shift_pload_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

    // Bits needed to count 0 .. width-1 bit periods.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/reg_shift_pload_if.sv
// Controller-side bundle of the reg_shift_pload transmitter.
// Handshake: a level start_tx seen in IDLE is accepted on that clk edge and tx_busy
// rises with the first bit; tx_done pulses one clk as tx_busy falls; a start_tx still
// high after tx_done is ignored until it has been low for at least one clk.
interface reg_shift_pload_if #(
    parameter int WIDTH = reg_shift_pload_pkg::DEFAULT_WIDTH
);
    logic [WIDTH-1:0] Din;
    logic             p_load;
    logic             start_tx;
    logic             clk_tx;
    logic             tx_done;
    logic             tx_busy;
    logic             Dout;

    modport master (
        output Din, p_load, start_tx, clk_tx,
        input  tx_done, tx_busy, Dout
    );

    modport slave (
        input  Din, p_load, start_tx, clk_tx,
        output tx_done, tx_busy, Dout
    );
endinterface

// File: rtl/reg_shift_pload_tick_edge_det.sv
// Rising-edge detector for the clk_tx bit-rate strobe; clk_tx is sampled, never used as a clock.
module reg_shift_pload_tick_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    output logic tick
);
    logic strobe_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe;
        end
    end

    assign tick = strobe & ~strobe_q;
endmodule

// File: rtl/reg_shift_pload.sv
// Parallel-load, serial-transmit shift register with busy/done handshake.
// Define REG_SHIFT_PLOAD_LSB_FIRST_EN to send LSB first; default is MSB first.
module reg_shift_pload
    import reg_shift_pload_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    reg_shift_pload_if.slave   bus,
    output state_t             state
);
    localparam int              CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] rot;
    logic             rot_out;
    logic             head;
    logic [CW-1:0]    count;
    logic             tick;
    logic             busy_r;
    logic             done_r;
    logic             dout_r;

    reg_shift_pload_tick_edge_det u_tick (
        .clk    (clk),
        .reset  (reset),
        .strobe (bus.clk_tx),
        .tick   (tick)
    );

    // Circular rotation keeps the loaded word intact after a full transmission.
    always_comb begin
        rot     = '0;
        rot_out = 1'b0;
        head    = 1'b0;
`ifdef REG_SHIFT_PLOAD_LSB_FIRST_EN
        rot     = {sreg[0], sreg[WIDTH-1:1]};
        rot_out = sreg[1];
        head    = sreg[0];
`else
        rot     = {sreg[WIDTH-2:0], sreg[WIDTH-1]};
        rot_out = sreg[WIDTH-2];
        head    = sreg[WIDTH-1];
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            sreg   <= '0;
            count  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.p_load) begin
                        sreg <= bus.Din;
                    end else if (bus.start_tx) begin
                        state  <= SHIFT;
                        busy_r <= 1'b1;
                        dout_r <= head;
                        count  <= '0;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        sreg <= rot;
                        if (count == LAST) begin
                            state  <= DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            dout_r <= 1'b0;
                        end else begin
                            dout_r <= rot_out;
                            count  <= count + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= bus.start_tx ? HOLD : IDLE;
                end
                HOLD: begin
                    if (!bus.start_tx) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_busy = busy_r;
    assign bus.tx_done = done_r;
    assign bus.Dout    = dout_r;
endmodule

// File: tb/tb_reg_shift_pload.sv
// Directed-plus-random bench for reg_shift_pload with a bit-queue reference model.
module tb_reg_shift_pload;
    import reg_shift_pload_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic   clk = 1'b0;
    logic   reset;
    state_t state;

    reg_shift_pload_if #(.WIDTH(W)) bus ();

    reg_shift_pload #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .state (state)
    );

    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [0:0] exp_q[$];

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input state_t obs, input state_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %s expected %s", tag, obs.name(), exp.name());
        end
    endtask

    // Reference: the serial stream is just the word's bits in transmit order.
    function automatic void model_load(input logic [W-1:0] word);
        exp_q.delete();
        for (int i = 0; i < W; i++) begin
`ifdef REG_SHIFT_PLOAD_LSB_FIRST_EN
            exp_q.push_back(word[i]);
`else
            exp_q.push_back(word[W-1-i]);
`endif
        end
    endfunction

    task automatic load_word(input logic [W-1:0] word, input int cycles);
        bus.Din    = word;
        bus.p_load = 1'b1;
        repeat (cycles) @(negedge clk);
        bus.p_load = 1'b0;
    endtask

    task automatic transmit(input logic [W-1:0] word, input bit hold, input bit disturb,
                            input int abort_at);
        logic [0:0] cur;
        int         gap;
        int         hi;
        model_load(word);
        bus.start_tx = 1'b1;
        @(negedge clk);
        cur = exp_q.pop_front();
        check_bit("accept_busy", bus.tx_busy, 1'b1);
        check_bit("accept_dout", bus.Dout, cur);
        check_state("accept_state", state, SHIFT);
        if (!hold) bus.start_tx = 1'b0;
        for (int i = 0; i < W; i++) begin
            bus.clk_tx = 1'b0;
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
                if (disturb && i == 5 && g == 0) begin
                    bus.Din      = $urandom;
                    bus.p_load   = 1'b1;
                    bus.start_tx = 1'b1;
                end
                if (disturb && i == 8 && g == 0) begin
                    bus.p_load   = 1'b0;
                    bus.start_tx = 1'b0;
                end
                @(negedge clk);
                check_bit("hold_dout", bus.Dout, cur);
                check_bit("hold_busy", bus.tx_busy, 1'b1);
                if (i == abort_at) begin
                    #2 reset = 1'b0;
                    #1;
                    check_bit("abort_busy", bus.tx_busy, 1'b0);
                    check_bit("abort_dout", bus.Dout, 1'b0);
                    check_bit("abort_done", bus.tx_done, 1'b0);
                    check_state("abort_state", state, IDLE);
                    bus.start_tx = 1'b0;
                    @(negedge clk);
                    check_bit("abort_no_done", bus.tx_done, 1'b0);
                    reset = 1'b1;
                    return;
                end
            end
            bus.clk_tx = 1'b1;
            @(negedge clk);
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                check_bit("bit_dout", bus.Dout, cur);
                check_bit("bit_busy", bus.tx_busy, 1'b1);
                hi = $urandom_range(0, 1);
                for (int h = 0; h < hi; h++) begin
                    @(negedge clk);
                    check_bit("high_dout", bus.Dout, cur);
                end
            end else begin
                check_bit("done_pulse", bus.tx_done, 1'b1);
                check_bit("done_busy", bus.tx_busy, 1'b0);
                check_bit("done_dout", bus.Dout, 1'b0);
                check_state("done_state", state, DONE);
            end
        end
        bus.clk_tx = 1'b0;
        @(negedge clk);
        check_bit("done_end", bus.tx_done, 1'b0);
        check_bit("post_busy", bus.tx_busy, 1'b0);
        check_bit("post_dout", bus.Dout, 1'b0);
        check_state("post_state", state, hold ? HOLD : IDLE);
        if (hold) begin
            repeat (3) begin
                @(negedge clk);
                check_state("hold_state", state, HOLD);
                check_bit("hold_no_busy", bus.tx_busy, 1'b0);
            end
            bus.start_tx = 1'b0;
            @(negedge clk);
            check_state("hold_release", state, IDLE);
            check_bit("hold_release_busy", bus.tx_busy, 1'b0);
        end
    endtask

    logic [W-1:0] word;
    logic [W-1:0] word2;

    initial begin
        reset        = 1'b0;
        bus.Din      = '0;
        bus.p_load   = 1'b0;
        bus.start_tx = 1'b0;
        bus.clk_tx   = 1'b0;
        #3;
        check_bit("rst_dout", bus.Dout, 1'b0);
        check_bit("rst_busy", bus.tx_busy, 1'b0);
        check_bit("rst_done", bus.tx_done, 1'b0);
        check_state("rst_state", state, IDLE);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_bit("idle_dout", bus.Dout, 1'b0);
        check_bit("idle_busy", bus.tx_busy, 1'b0);

`ifdef REG_SHIFT_PLOAD_LSB_FIRST_EN
        word = 32'h0000_0001;
`else
        word = 32'hF0F0_FF0F;
`endif
        load_word(word, 2);
        transmit(word, 1'b0, 1'b0, -1);
        transmit(word, 1'b0, 1'b1, -1);
        transmit(word, 1'b0, 1'b0, -1);

        word2        = $urandom;
        bus.Din      = word2;
        bus.p_load   = 1'b1;
        bus.start_tx = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_bit("prio_busy", bus.tx_busy, 1'b0);
            check_state("prio_state", state, IDLE);
        end
        bus.p_load   = 1'b0;
        bus.start_tx = 1'b0;
        @(negedge clk);
        transmit(word2, 1'b0, 1'b0, -1);
        transmit(word2, 1'b1, 1'b0, -1);

        for (int n = 0; n < 4; n++) begin
            word = $urandom;
            load_word(word, 1);
            transmit(word, 1'b0, 1'b0, -1);
        end

        word = $urandom;
        load_word(word, 1);
        transmit(word, 1'b0, 1'b0, 10);
        transmit('0, 1'b0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/reg_shift_pload.md
Name: reg_shift_pload

Overview:
- Parallel-load, serial-transmit shift register (PISO) for the calculator's result output path.
- A WIDTH-bit word is captured from Din on p_load, then sent one bit per transmit tick on Dout after start_tx.
- tx_busy and tx_done give a simple handshake to the controller.
- Single clock domain. clk_tx is a slower strobe generated synchronously from clk, not a second clock.

Parameters:
- WIDTH, 32, data word / shift register width, in bits (≥2).

Ports:
- clk  in  1  system clock; all flops use its rising edge.
- reset  in  1  asynchronous, active-low reset.
- Din  in  WIDTH  parallel data word.
- p_load  in  1  level; load Din into the shift register when idle.
- start_tx  in  1  level; request a transmission.
- clk_tx  in  1  bit-rate strobe, synchronous to clk; each rising edge advances one bit.
- tx_done  out  1  one-clk pulse when the last bit period ends.
- tx_busy  out  1  high while a transmission is in progress.
- Dout  out  1  serial data, registered.

Behaviour:
- Reset (reset=0, asynchronous): sreg=0, bit count=0, state=IDLE, clk_tx_q=0, tx_busy=0, tx_done=0, Dout=0.
- Tick: tick = clk_tx & ~clk_tx_q. clk_tx_q is clk_tx registered every clk cycle.
- State IDLE:
  - p_load=1: sreg<=Din; stay IDLE. p_load has priority over start_tx in the same cycle.
  - else start_tx=1: go to SHIFT; tx_busy<=1; Dout<=sreg[WIDTH-1]; count<=0.
- State SHIFT:
  - p_load and start_tx are ignored.
  - On tick with count<WIDTH-1: rotate sreg left by 1, MSB wraps to LSB; Dout<=next bit (new MSB); count++.
  - On tick with count==WIDTH-1: rotate once more, so sreg again equals the loaded word; go to DONE; tx_busy<=0; tx_done<=1; Dout<=0.
- State DONE: lasts exactly 1 clk. tx_done<=0. Go to HOLD if start_tx=1, else IDLE.
- State HOLD: wait for start_tx=0, then go to IDLE. A held-high start_tx therefore yields exactly one transmission.
- Bit order: MSB first.
- Bit timing: each bit is held on Dout for one full clk_tx period (the interval between ticks). The first bit appears 1 clk after start is accepted, not aligned to a tick.
- A second start_tx without a reload retransmits the same word, because the rotation is circular.
- Mid-operation reset: aborts immediately; all outputs return to reset values.
- clk_tx is sampled only; it is never used as a clock.

Optional Feature:
- Macro: REG_SHIFT_PLOAD_LSB_FIRST_EN.
- Defined: transmit LSB first. Rotate right; Dout takes sreg[0] at start and after each tick.
- Undefined: MSB-first rotate-left, as described above.
- Handshake and timing are identical in both cases.

Decomposition:
- Package reg_shift_pload_pkg holds:
  - state enum {IDLE, SHIFT, DONE, HOLD};
  - default width constant (32);
  - count width function ($clog2(WIDTH)).
- One natural sub-module: tick_edge_det (register plus AND-NOT rising-edge detector on clk_tx). Everything else stays in one always block plus an FSM.

Test Plan:
- Reset: hold reset=0 for 5 ns -> Dout=0, tx_busy=0, tx_done=0. Release reset; outputs remain idle.
- Load and send (clk 10 ns, clk_tx 20 ns):
  - Stimulus: Din=32'hF0F0FF0F, p_load=1 for 2 clks, then p_load=0, start_tx=1.
  - Response: tx_busy rises 1 clk later; Dout sequence is 1111 0000 1111 0000 1111 1111 0000 1111, each bit held 2 clks; tx_done pulses exactly 1 clk after the 32nd tick; then tx_busy=0 and Dout=0.
- Ignore during busy: mid-transmission, set Din=32'h12345678 with p_load=1 -> serial stream is unchanged (still F0F0FF0F). Restart after start_tx goes low -> F0F0FF0F is sent again, confirming circular retention.
- Priority and hold:
  - p_load=1 and start_tx=1 together in IDLE -> load only, no busy.
  - start_tx held high across completion -> no second transmission until start_tx drops and rises again.
- Async abort: assert reset at bit 10 -> tx_busy=0 and Dout=0 immediately, without a clk edge; no tx_done pulse.
- LSB_FIRST_EN build: Din=32'h00000001 -> first bit 1, followed by 31 zeros.
